uart_cmd_engine: RTL and testbench

Host-side command engine on the user side of the `uart` block: consumes bytes from the UART RX FIFO, parses fixed-format request frames, performs single register reads/writes on a simple local bus, and returns a 4-byte response frame through the UART TX FIFO. It is the protocol peer of the UART's FIFO interface: it drives `rd_uart`/`wr_uart` and observes `rx_empty`/`tx_full`. It gives a PC a byte-level register access path into the design.

---
 rtl/uart_cmd_engine_pkg.sv | 29 ++
 rtl/uart_cmd_engine_if.sv | 25 ++
 rtl/uart_cmd_engine_timer.sv | 30 +++
 rtl/uart_cmd_engine.sv | 121 ++++++++++++
 tb/tb_uart_cmd_engine.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_cmd_engine_pkg.sv
// Shared constants, state encoding and helpers for the UART command engine.
package uart_cmd_pkg;

  localparam logic [7:0] SYNC_REQ    = 8'hA5;
  localparam logic [7:0] SYNC_RSP    = 8'h5A;

  localparam logic [7:0] CMD_WR      = 8'h01;
  localparam logic [7:0] CMD_RD      = 8'h02;

  localparam logic [7:0] STS_OK      = 8'h00;
  localparam logic [7:0] STS_BAD_CHK = 8'hE1;
  localparam logic [7:0] STS_BAD_CMD = 8'hE2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_CHK,
    ST_EXEC,
    ST_RDWAIT,
    ST_RESP
  } state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/uart_cmd_engine_if.sv
// UART FIFO handshake and local register bus seen by the command engine.
interface uart_cmd_engine_if;
  logic       rx_empty;
  logic [7:0] r_data;
  logic       rd_uart;
  logic       tx_full;
  logic [7:0] w_data;
  logic       wr_uart;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;
  logic [7:0] err_cnt;

  modport master (
    input  rx_empty, r_data, tx_full, reg_rdata,
    output rd_uart, w_data, wr_uart, reg_addr, reg_wdata, reg_we, reg_re, err_cnt
  );

  modport slave (
    output rx_empty, r_data, tx_full, reg_rdata,
    input  rd_uart, w_data, wr_uart, reg_addr, reg_wdata, reg_we, reg_re, err_cnt
  );
endinterface

// File: rtl/uart_cmd_engine_timer.sv
// Inter-byte timeout counter: counts enabled cycles since the last clear, flags at TO_CYCLES.
module cmd_timeout_timer #(
  parameter int unsigned TO_CYCLES = 1_000_000,
  parameter int unsigned TO_BITS   = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  logic [TO_BITS-1:0] cnt_q, cnt_d;

  assign expired_o = (cnt_q == TO_BITS'(TO_CYCLES));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)
      cnt_d = '0;
    else if (enable_i && !expired_o)
      cnt_d = cnt_q + TO_BITS'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_cmd_engine.sv
// UART command engine: parses A5-framed register requests from the RX FIFO, answers with 5A frames.
// Build option UART_CMD_TIMEOUT_EN adds an inter-byte timeout that drops stalled frames.
module uart_cmd_engine
  import uart_cmd_pkg::*;
#(
  parameter int unsigned TO_CYCLES = 1_000_000,
  parameter int unsigned TO_BITS   = 20
) (
  input logic clk,
  input logic reset,
  uart_cmd_engine_if.master bus
);

  if (TO_BITS < 1 || TO_BITS > 31 || TO_CYCLES >= (32'd1 << TO_BITS)) begin : g_bad_to_bits
    $error("uart_cmd_engine: TO_BITS too small for TO_CYCLES");
  end

  state_e     state_q;
  logic [1:0] idx_q;
  logic [7:0] cmd_q, addr_q, wdata_q, status_q, rdata_q, err_q;
  logic       we_q, re_q;
  logic       receiving, in_frame, pop, push, to_expired;
  logic [7:0] resp_byte;

  assign receiving = state_q inside {ST_IDLE, ST_CMD, ST_ADDR, ST_DATA, ST_CHK};
  assign in_frame  = state_q inside {ST_CMD, ST_ADDR, ST_DATA, ST_CHK};
  assign pop       = reset && receiving && !bus.rx_empty;
  assign push      = reset && (state_q == ST_RESP) && !bus.tx_full;

  always_comb begin
    resp_byte = SYNC_RSP;
    case (idx_q)
      2'd0: resp_byte = SYNC_RSP;
      2'd1: resp_byte = status_q;
      2'd2: resp_byte = rdata_q;
      2'd3: resp_byte = status_q ^ rdata_q;
      default: resp_byte = SYNC_RSP;
    endcase
  end

  assign bus.rd_uart   = pop;
  assign bus.wr_uart   = push;
  assign bus.w_data    = reset ? resp_byte : 8'h00;
  assign bus.reg_addr  = addr_q;
  assign bus.reg_wdata = wdata_q;
  assign bus.reg_we    = we_q;
  assign bus.reg_re    = re_q;
  assign bus.err_cnt   = err_q;

`ifdef UART_CMD_TIMEOUT_EN
  cmd_timeout_timer #(.TO_CYCLES(TO_CYCLES), .TO_BITS(TO_BITS)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (pop || !in_frame),
    .enable_i  (in_frame),
    .expired_o (to_expired)
  );
`else
  assign to_expired = 1'b0;
`endif

  // The request is judged as the CHK byte is popped so the bus strobe is live during EXEC
  // and the read slave's registered data is ready by the end of RDWAIT.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      idx_q    <= 2'd0;
      cmd_q    <= 8'h00;
      addr_q   <= 8'h00;
      wdata_q  <= 8'h00;
      status_q <= STS_OK;
      rdata_q  <= 8'h00;
      err_q    <= 8'h00;
      we_q     <= 1'b0;
      re_q     <= 1'b0;
    end else begin
      we_q <= 1'b0;
      re_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (pop && bus.r_data == SYNC_REQ) state_q <= ST_CMD;
        ST_CMD:  if (pop) begin cmd_q   <= bus.r_data; state_q <= ST_ADDR; end
        ST_ADDR: if (pop) begin addr_q  <= bus.r_data; state_q <= ST_DATA; end
        ST_DATA: if (pop) begin wdata_q <= bus.r_data; state_q <= ST_CHK;  end
        ST_CHK: if (pop) begin
          state_q <= ST_EXEC;
          rdata_q <= 8'h00;
          if (bus.r_data != (cmd_q ^ addr_q ^ wdata_q)) begin
            status_q <= STS_BAD_CHK;
          end else if (cmd_q == CMD_WR) begin
            status_q <= STS_OK;
            we_q     <= 1'b1;
          end else if (cmd_q == CMD_RD) begin
            status_q <= STS_OK;
            re_q     <= 1'b1;
          end else begin
            status_q <= STS_BAD_CMD;
          end
        end
        ST_EXEC: begin
          idx_q   <= 2'd0;
          if (status_q != STS_OK) err_q <= sat_inc8(err_q);
          state_q <= re_q ? ST_RDWAIT : ST_RESP;
        end
        ST_RDWAIT: begin
          rdata_q <= bus.reg_rdata;
          state_q <= ST_RESP;
        end
        ST_RESP: if (push) begin
          idx_q <= idx_q + 2'd1;
          if (idx_q == 2'd3) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
      if (to_expired && in_frame) begin
        state_q <= ST_IDLE;
        err_q   <= sat_inc8(err_q);
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_engine.sv
// Randomized self-checking bench for uart_cmd_engine against a frame-level reference model.
`timescale 1ns/1ps
module tb_uart_cmd_engine;

  typedef logic [7:0] byte_q_t [$];

  logic clk = 1'b0;
  logic reset;

  uart_cmd_engine_if bus();

  uart_cmd_engine #(.TO_CYCLES(100), .TO_BITS(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [7:0] rx_q [$];
  logic [7:0] tx_got [$];
  logic [7:0] slave_mem [256];
  logic [7:0] model_mem [256];
  int   cyc = 0, pops_total = 0, we_cnt = 0, re_cnt = 0;
  int   last_pop_cyc = 0, first_push_cyc = 0;
  logic [7:0] we_addr, we_data, re_addr;
  bit   re_seen, pop_now;
  int   gap_pct = 0, bp_pct = 0;
  bit   txf_hold = 1'b0;
  int   err_exp = 0;

  // FIFO/slave environment: observe at negedge, update inputs just after posedge.
  initial begin
    bus.rx_empty  = 1'b1;
    bus.r_data    = 8'h00;
    bus.tx_full   = 1'b0;
    bus.reg_rdata = 8'h00;
    forever begin
      @(negedge clk);
      pop_now = (bus.rd_uart === 1'b1);
      if (pop_now) begin pops_total++; last_pop_cyc = cyc; end
      if (bus.wr_uart === 1'b1) begin
        if (tx_got.size() == 0) first_push_cyc = cyc;
        tx_got.push_back(bus.w_data);
      end
      if (bus.reg_we === 1'b1) begin
        we_cnt++;
        we_addr = bus.reg_addr;
        we_data = bus.reg_wdata;
        slave_mem[bus.reg_addr] = bus.reg_wdata;
      end
      re_seen = (bus.reg_re === 1'b1);
      if (re_seen) begin re_cnt++; re_addr = bus.reg_addr; end
      @(posedge clk);
      #1;
      cyc++;
      if (pop_now && rx_q.size() > 0) void'(rx_q.pop_front());
      bus.reg_rdata = re_seen ? slave_mem[re_addr] : 8'($urandom);
      if (rx_q.size() > 0 && int'($urandom_range(99, 0)) >= gap_pct) begin
        bus.rx_empty = 1'b0;
        bus.r_data   = rx_q[0];
      end else begin
        bus.rx_empty = 1'b1;
        bus.r_data   = 8'($urandom);
      end
      bus.tx_full = txf_hold || (int'($urandom_range(99, 0)) < bp_pct);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic wait_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset_checks(input string tag);
    reset = 1'b0;
    txf_hold = 1'b0;
    rx_q.delete();
    rx_q.push_back(8'hA5);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq({tag, "_rd_uart"},   32'(bus.rd_uart),   32'd0);
    check_eq({tag, "_wr_uart"},   32'(bus.wr_uart),   32'd0);
    check_eq({tag, "_w_data"},    32'(bus.w_data),    32'd0);
    check_eq({tag, "_strobes"},   {30'd0, bus.reg_we, bus.reg_re}, 32'd0);
    check_eq({tag, "_err_cnt"},   32'(bus.err_cnt),   32'd0);
    check_eq({tag, "_addr_data"}, {16'd0, bus.reg_addr, bus.reg_wdata}, 32'd0);
    rx_q.delete();
    err_exp = 0;
    @(posedge clk);
    #2 reset = 1'b1;
  endtask

  // Feeds one frame (optional junk prefix + 5 request bytes) and checks the full transaction.
  task automatic run_frame(input byte_q_t fr, input int hold_cycles);
    logic [7:0] c, a, d, k, st, rd;
    bit   exp_we, exp_re;
    logic [31:0] exp_resp;
    int   pops0, we0, re0, n, guard;
    n = fr.size();
    c = fr[n-4]; a = fr[n-3]; d = fr[n-2]; k = fr[n-1];
    exp_we = 1'b0; exp_re = 1'b0; rd = 8'h00;
    if (k != (c ^ a ^ d))  st = 8'hE1;
    else if (c == 8'h01) begin st = 8'h00; exp_we = 1'b1; end
    else if (c == 8'h02) begin st = 8'h00; exp_re = 1'b1; rd = model_mem[a]; end
    else                   st = 8'hE2;
    if (st != 8'h00 && err_exp < 255) err_exp++;
    exp_resp = {8'h5A, st, rd, st ^ rd};

    tx_got.delete();
    pops0 = pops_total; we0 = we_cnt; re0 = re_cnt;
    if (hold_cycles > 0) txf_hold = 1'b1;
    foreach (fr[i]) rx_q.push_back(fr[i]);
    rx_q.push_back(8'h00);

    if (hold_cycles > 0) begin
      guard = 0;
      while (pops_total - pops0 < n && guard < 300) begin wait_cycle(); guard++; end
      repeat (hold_cycles + 3) wait_cycle();
      check_eq("push_while_full", tx_got.size(), 32'd0);
      txf_hold = 1'b0;
    end

    guard = 0;
    while (tx_got.size() < 4 && guard < 500) begin wait_cycle(); guard++; end
    if (tx_got.size() < 4) begin
      check_eq("resp_byte_count", tx_got.size(), 32'd4);
    end else begin
      check_eq("resp_frame", {tx_got[0], tx_got[1], tx_got[2], tx_got[3]}, exp_resp);
      check_eq("pops_in_frame", pops_total - pops0, n);
      check_eq("we_pulses", we_cnt - we0, 32'(exp_we));
      check_eq("re_pulses", re_cnt - re0, 32'(exp_re));
      if (exp_we) check_eq("we_addr_data", {16'd0, we_addr, we_data}, {16'd0, a, d});
      check_eq("err_cnt", 32'(bus.err_cnt), err_exp);
      if (bp_pct == 0 && hold_cycles == 0)
        check_eq("latency", first_push_cyc - last_pop_cyc, exp_re ? 32'd3 : 32'd2);
    end
    if (exp_we) model_mem[a] = d;

    guard = 0;
    while (rx_q.size() > 0 && guard < 200) begin wait_cycle(); guard++; end
    wait_cycle();
  endtask

  byte_q_t    fr;
  logic [7:0] c, a, d, k, j;
  int         kind, np, guard;

  initial begin
    reset = 1'b0;
    for (int i = 0; i < 256; i++) begin
      slave_mem[i] = 8'($urandom);
      model_mem[i] = slave_mem[i];
    end
    slave_mem[8'h20] = 8'h7E;
    model_mem[8'h20] = 8'h7E;

    do_reset_checks("reset");

    run_frame('{8'hA5, 8'h01, 8'h10, 8'h3C, 8'h2D}, 0);
    run_frame('{8'hA5, 8'h02, 8'h20, 8'h00, 8'h22}, 0);
    run_frame('{8'hA5, 8'h01, 8'h10, 8'h3C, 8'h00}, 0);
    check_eq("err_after_badchk", 32'(bus.err_cnt), 32'd1);
    run_frame('{8'hA5, 8'h07, 8'h00, 8'h00, 8'h07}, 0);
    run_frame('{8'hFF, 8'h00, 8'hA5, 8'h02, 8'h01, 8'h00, 8'h03}, 0);
    run_frame('{8'hA5, 8'h02, 8'h10, 8'h00, 8'h12}, 10);
    run_frame('{8'hA5, 8'h01, 8'hA5, 8'hA5, 8'h01}, 0);

    for (int f = 0; f < 60; f++) begin
      gap_pct = (f % 3 == 0) ? 0 : 30;
      bp_pct  = (f % 4 == 0) ? 0 : 25;
      kind = int'($urandom_range(3, 0));
      a = 8'($urandom_range(7, 0));
      d = 8'($urandom);
      if ($urandom_range(3, 0) == 0) d = 8'hA5;
      c = ($urandom_range(1, 0) == 0) ? 8'h01 : 8'h02;
      if (kind == 3) begin
        c = 8'($urandom);
        if (c == 8'h01 || c == 8'h02) c = 8'h80;
      end
      k = c ^ a ^ d;
      if (kind == 2) k = k ^ 8'($urandom_range(255, 1));
      fr.delete();
      np = int'($urandom_range(2, 0));
      for (int p = 0; p < np; p++) begin
        j = 8'($urandom);
        if (j == 8'hA5) j = 8'h5A;
        fr.push_back(j);
      end
      fr.push_back(8'hA5); fr.push_back(c); fr.push_back(a); fr.push_back(d); fr.push_back(k);
      run_frame(fr, 0);
    end
    gap_pct = 0;
    bp_pct  = 0;

`ifdef UART_CMD_TIMEOUT_EN
    tx_got.delete();
    rx_q.push_back(8'hA5);
    rx_q.push_back(8'h01);
    guard = 0;
    while (rx_q.size() > 0 && guard < 50) begin wait_cycle(); guard++; end
    repeat (88) wait_cycle();
    check_eq("timeout_early", 32'(bus.err_cnt), err_exp);
    repeat (30) wait_cycle();
    if (err_exp < 255) err_exp++;
    check_eq("timeout_err", 32'(bus.err_cnt), err_exp);
    check_eq("timeout_no_tx", tx_got.size(), 32'd0);
    run_frame('{8'hA5, 8'h02, 8'h20, 8'h00, 8'h22}, 0);
`endif

    for (int f = 0; f < 260; f++) run_frame('{8'hA5, 8'h01, 8'h00, 8'h00, 8'hFF}, 0);
    check_eq("err_saturated", 32'(bus.err_cnt), 32'd255);

    tx_got.delete();
    rx_q.push_back(8'hA5); rx_q.push_back(8'h01); rx_q.push_back(8'h33);
    rx_q.push_back(8'h44); rx_q.push_back(8'h01 ^ 8'h33 ^ 8'h44);
    guard = 0;
    while (tx_got.size() < 2 && guard < 100) begin wait_cycle(); guard++; end
    check_eq("pre_reset_pushes", tx_got.size(), 32'd2);
    model_mem[8'h33] = 8'h44;
    do_reset_checks("rst_resp");
    repeat (10) wait_cycle();
    check_eq("no_push_after_reset", tx_got.size(), 32'd2);
    run_frame('{8'hA5, 8'h02, 8'h33, 8'h00, 8'h31}, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
